cc_eval_unit: RTL
=================

Name: cc_eval_unit

Overview:
- Consumer end of the ALU condition-flag interface.
- Captures the 3-bit flag vectors produced by the execute-stage ALU ops (add/sub/and/xor) into the architectural condition-code register.
- Evaluates Y86 branch and cmov conditions (ifun 0-6) against that register and returns a registered Cnd result to the execute/memory pipeline register.
- Keeps taken and not-taken branch counters for debug.

Parameters:
- CNT_W, 32, width of each branch-statistics counter.
- CC_RESET, 3'b001, reset value of the CC register, encoded {OF,SF,ZF}; default ZF=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all state, outputs hold.
- set_cc  in  1  an OPq completes this cycle; load flags_in into CC.
- flags_in  in  3  ALU flag vector: [0]=ZF, [1]=SF, [2]=OF.
- eval_valid  in  1  an evaluation request is present.
- eval_is_jmp  in  1  1 = jXX (counted); 0 = cmovXX (not counted).
- eval_ifun  in  4  condition code: 0=always, 1=le, 2=l, 3=e, 4=ne, 5=ge, 6=g.
- cnd_valid  out  1  cnd is valid this cycle.
- cnd  out  1  condition result.
- cnd_err  out  1  eval_ifun was greater than 6.
- cc_q  out  3  current CC register value.
- taken_cnt  out  CNT_W  jXX evaluations that produced cnd=1.
- ntaken_cnt  out  CNT_W  jXX evaluations that produced cnd=0.

Behaviour:
- Reset: asynchronous, active-high. Forces cc_q=CC_RESET and zeroes cnd_valid, cnd, cnd_err, taken_cnt and ntaken_cnt.
- CC update:
  - On a clk edge with set_cc=1 and stall=0, cc_q <= flags_in.
  - Otherwise cc_q holds.
- Evaluation:
  - Uses the CC value present before the same-edge update (standard PIPE semantics).
  - le = (SF^OF)|ZF; l = SF^OF; e = ZF; ne = ~ZF; ge = ~(SF^OF); g = ~(SF^OF)&~ZF; always = 1.
- Latency: one cycle. eval_valid sampled at edge N (stall=0) gives cnd_valid=1 and cnd/cnd_err during cycle N+1.
  - cnd_valid is a one-cycle pulse per accepted request; back-to-back requests produce back-to-back pulses.
- Illegal ifun (7-15): cnd=0, cnd_err=1, cnd_valid=1. Counters are not updated.
- Counters:
  - On an accepted jXX evaluation, exactly one counter increments.
  - Counters wrap modulo 2^CNT_W with no saturation.
  - Only valid (non-error) evaluations are counted.
- Stall: when stall=1, every register holds, including cnd_valid. A pending result stays visible until the stall drops, then clears unless a new request is accepted.
- Simultaneous set_cc and eval_valid: evaluation sees the old CC, and the register then takes flags_in.
- Reset mid-operation: an in-flight result is discarded; cnd_valid is 0 in the first cycle after release.

Optional Feature:
- Macro: CC_BYPASS_EN.
- When defined: if set_cc=1 and eval_valid=1 on the same edge and eval_is_jmp=0 (cmov), the evaluation uses flags_in instead of cc_q. This forwards the prior OPq's flags for a fused op/cmov pair. jXX evaluation is unchanged.
- When undefined: all evaluations use cc_q, exactly as in Behaviour.

Decomposition:
- Shared package cc_pkg holds:
  - CC bit-index constants: ZF=0, SF=1, OF=2.
  - ifun enum: C_ALWAYS, C_LE, C_L, C_E, C_NE, C_GE, C_G.
  - The CC_RESET default.
- One natural sub-module, cond_logic: a purely combinational map from (cc, ifun) to (cnd, err). It is reused by the decode-stage branch predictor check.

Test Plan:
- Reset with reset=1 for 2 cycles then release -> cc_q=3'b001, taken_cnt=ntaken_cnt=0. An eval with ifun=3 (e) gives cnd=1 one cycle later.
- Set flags_in=3'b010 (SF=1), then sweep ifun 0..6 -> cnd sequence 1,1,1,0,1,0,0 on consecutive cnd_valid pulses.
- Same-edge set_cc with flags_in=3'b001 and eval of ifun=3 while cc_q=3'b000:
  - Without CC_BYPASS_EN -> cnd=0.
  - With CC_BYPASS_EN and eval_is_jmp=0 -> cnd=1.
  - In both builds cc_q becomes 3'b001.
- 5 jXX evals (3 taken, 2 not), then ifun=9 -> taken_cnt=3, ntaken_cnt=2, last pulse has cnd_err=1 and cnd=0, counters unchanged.
- Raise stall for 3 cycles during a pending result with set_cc=1 -> cnd_valid held high, cc_q unchanged. After the stall drops, cnd_valid clears.
- Preload taken_cnt to 2^CNT_W-1 via a force, then one taken jXX -> taken_cnt=0. Assert reset mid-request -> cnd_valid=0 the next cycle.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared condition-code definitions: flag bit positions, Y86 condition codes, CC reset value.
package cc_pkg;

    localparam int ZF = 0;
    localparam int SF = 1;
    localparam int OF = 2;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } ifun_e;

    localparam logic [2:0] CC_RESET_DEFAULT = 3'b001;

endpackage

// File: rtl/cc_eval_unit_if.sv
// Request/result bundle between the execute stage and the condition-code evaluation unit.
interface cc_eval_unit_if #(parameter int CNT_W = 32);

    logic             stall;
    logic             set_cc;
    logic [2:0]       flags_in;
    logic             eval_valid;
    logic             eval_is_jmp;
    logic [3:0]       eval_ifun;
    logic             cnd_valid;
    logic             cnd;
    logic             cnd_err;
    logic [2:0]       cc_q;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] ntaken_cnt;

    modport master (
        output stall, set_cc, flags_in, eval_valid, eval_is_jmp, eval_ifun,
        input  cnd_valid, cnd, cnd_err, cc_q, taken_cnt, ntaken_cnt
    );

    modport slave (
        input  stall, set_cc, flags_in, eval_valid, eval_is_jmp, eval_ifun,
        output cnd_valid, cnd, cnd_err, cc_q, taken_cnt, ntaken_cnt
    );

endinterface

// File: rtl/cc_eval_unit_cond_logic.sv
// Combinational Y86 condition evaluation; also used by the decode-stage predictor check.
module cond_logic
    import cc_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       err
);

    logic lt;

    assign lt = cc[SF] ^ cc[OF];

    always_comb begin
        cnd = 1'b0;
        err = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | cc[ZF];
            C_L:      cnd = lt;
            C_E:      cnd = cc[ZF];
            C_NE:     cnd = ~cc[ZF];
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~cc[ZF];
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/cc_eval_unit.sv
// Condition-code register, registered branch/cmov evaluation and jXX statistics.
// Optional build macro CC_BYPASS_EN: a cmov fused with a same-edge set_cc evaluates flags_in.
module cc_eval_unit
    import cc_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [2:0] CC_RESET = CC_RESET_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    cc_eval_unit_if.slave bus
);

    logic [2:0]       cc_r;
    logic [2:0]       eval_cc;
    logic             cnd_c;
    logic             err_c;
    logic             valid_r;
    logic             cnd_r;
    logic             err_r;
    logic [CNT_W-1:0] taken_r;
    logic [CNT_W-1:0] ntaken_r;

    always_comb begin
        eval_cc = cc_r;
`ifdef CC_BYPASS_EN
        if (bus.set_cc && bus.eval_valid && !bus.eval_is_jmp)
            eval_cc = bus.flags_in;
`endif
    end

    cond_logic u_cond (
        .cc   (eval_cc),
        .ifun (bus.eval_ifun),
        .cnd  (cnd_c),
        .err  (err_c)
    );

    // Stall freezes everything, so a pending result stays visible until it drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_r     <= CC_RESET;
            valid_r  <= 1'b0;
            cnd_r    <= 1'b0;
            err_r    <= 1'b0;
            taken_r  <= '0;
            ntaken_r <= '0;
        end else if (!bus.stall) begin
            if (bus.set_cc)
                cc_r <= bus.flags_in;
            valid_r <= bus.eval_valid;
            cnd_r   <= bus.eval_valid & cnd_c;
            err_r   <= bus.eval_valid & err_c;
            if (bus.eval_valid && bus.eval_is_jmp && !err_c) begin
                if (cnd_c)
                    taken_r <= taken_r + CNT_W'(1);
                else
                    ntaken_r <= ntaken_r + CNT_W'(1);
            end
        end
    end

    assign bus.cc_q       = cc_r;
    assign bus.cnd_valid  = valid_r;
    assign bus.cnd        = cnd_r;
    assign bus.cnd_err    = err_r;
    assign bus.taken_cnt  = taken_r;
    assign bus.ntaken_cnt = ntaken_r;

endmodule
